ifetch_mem_ctrl: RTL and testbench

IFETCH_MEM_CTRL -- requirements
Module: ifetch_mem_ctrl

---
 rtl/ifetch_mem_ctrl_pkg.sv | 16 +
 rtl/ifetch_mem_ctrl.sv | 102 ++++++++++
 tb/tb_ifetch_mem_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_mem_ctrl_pkg.sv
// Shared constants for the instruction-fetch memory controller: FSM encodings,
// RAM latency default and the instruction-length decode helper.
package ifetch_mem_ctrl_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RD   = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int RAM_LAT_DEFAULT = 1;

   // RISC-V length rule: low two bits of the first byte other than 2'b11 mean a 16-bit instruction.
   function automatic logic is_short_instr(input logic [7:0] first_byte);
      return first_byte[1:0] != 2'b11;
   endfunction

endpackage

// File: rtl/ifetch_mem_ctrl.sv
// Byte-serial instruction fetch: on an icache miss, reads 2 or 4 bytes from RAM,
// assembles them little-endian and delivers one instruction with a valid pulse.
module ifetch_mem_ctrl
   import ifetch_mem_ctrl_pkg::*;
#(
   parameter int RAM_LAT = RAM_LAT_DEFAULT
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        need_flush_in,
   input  logic        miss_in,
   input  logic [31:0] miss_addr_in,
   input  logic [7:0]  ram_din,
   output logic [31:0] ram_a,
   output logic        ram_wr,
   output logic        mem_busy_out,
   output logic        mem_valid_out,
   output logic [31:0] mem_instr_out
);

   if (RAM_LAT != 1) begin : g_unsupported_lat
      $error("ifetch_mem_ctrl supports only RAM_LAT == 1");
   end

   logic [1:0]  state;
   logic [1:0]  k;
   logic [31:0] base;
   logic [7:0]  asm_q [4];

   assign ram_wr = 1'b0;

   // NOTE: all state here uses non-blocking assignments so every register samples
   // pre-edge values; blocking would let later statements see this edge's updates.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state         <= ST_IDLE;
         k             <= 2'd0;
         base          <= 32'd0;
         ram_a         <= 32'd0;
         mem_busy_out  <= 1'b0;
         mem_valid_out <= 1'b0;
         mem_instr_out <= 32'd0;
         // NOTE: the assembly bytes are a tiny register file, not a RAM macro, so
         // resetting them is cheap and keeps the hold-last-value output deterministic.
         for (int i = 0; i < 4; i++) asm_q[i] <= 8'd0;
      end else if (rdy_in) begin
         if (need_flush_in) begin
            state         <= ST_IDLE;
            k             <= 2'd0;
            ram_a         <= 32'd0;
            mem_busy_out  <= 1'b0;
            mem_valid_out <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  ram_a         <= 32'd0;
                  mem_busy_out  <= 1'b0;
                  mem_valid_out <= 1'b0;
                  if (miss_in) begin
                     base         <= miss_addr_in;
                     k            <= 2'd0;
                     ram_a        <= miss_addr_in;
                     mem_busy_out <= 1'b1;
                     state        <= ST_RD;
                  end
               end
               ST_RD: begin
                  asm_q[k] <= ram_din;
                  ram_a    <= base + 32'(k) + 32'd1;
                  k        <= k + 2'd1;
                  // asm_q[0] was captured on the previous edge; ram_din is byte k now.
                  if (k == 2'd1 && is_short_instr(asm_q[0])) begin
                     state         <= ST_DONE;
                     mem_valid_out <= 1'b1;
                     mem_instr_out <= {16'h0000, ram_din, asm_q[0]};
                  end else if (k == 2'd3) begin
                     state         <= ST_DONE;
                     mem_valid_out <= 1'b1;
                     mem_instr_out <= {ram_din, asm_q[2], asm_q[1], asm_q[0]};
                  end
               end
               ST_DONE: begin
                  state         <= ST_IDLE;
                  k             <= 2'd0;
                  ram_a         <= 32'd0;
                  mem_busy_out  <= 1'b0;
                  mem_valid_out <= 1'b0;
               end
               default: begin
                  state         <= ST_IDLE;
                  k             <= 2'd0;
                  ram_a         <= 32'd0;
                  mem_busy_out  <= 1'b0;
                  mem_valid_out <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ifetch_mem_ctrl.sv
// Self-checking bench for ifetch_mem_ctrl: transaction-level model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_ifetch_mem_ctrl;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic        rdy_in = 1'b1;
   logic        need_flush_in = 1'b0;
   logic        miss_in = 1'b0;
   logic [31:0] miss_addr_in = 32'd0;
   logic [7:0]  ram_din;
   logic [31:0] ram_a;
   logic        ram_wr;
   logic        mem_busy_out;
   logic        mem_valid_out;
   logic [31:0] mem_instr_out;

   int total = 0;
   int bad   = 0;

   always #5 clk_in = ~clk_in;

   ifetch_mem_ctrl dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .rdy_in        (rdy_in),
      .need_flush_in (need_flush_in),
      .miss_in       (miss_in),
      .miss_addr_in  (miss_addr_in),
      .ram_din       (ram_din),
      .ram_a         (ram_a),
      .ram_wr        (ram_wr),
      .mem_busy_out  (mem_busy_out),
      .mem_valid_out (mem_valid_out),
      .mem_instr_out (mem_instr_out)
   );

   function automatic logic [7:0] ram_byte(input logic [31:0] a);
      case (a)
         32'h0000_0100: return 8'h01;
         32'h0000_0101: return 8'h45;
         32'h0000_0200: return 8'h93;
         32'h0000_0201: return 8'h00;
         32'h0000_0202: return 8'h10;
         32'h0000_0203: return 8'h00;
         32'h0000_0300: return 8'h13;
         32'h0000_0301: return 8'h05;
         32'h0000_0302: return 8'ha0;
         32'h0000_0303: return 8'h00;
         32'h0000_0400: return 8'h82;
         32'h0000_0401: return 8'h80;
         32'hFFFF_FFFE: return 8'h37;
         32'hFFFF_FFFF: return 8'h12;
         32'h0000_0000: return 8'h34;
         32'h0000_0001: return 8'h56;
         default:       return 8'hc6;
      endcase
   endfunction

   // RAM model: the byte for the address presented this cycle is sampled at the next edge.
   assign ram_din = ram_byte(ram_a);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: after acceptance, edge i presents base+i; the instruction is
   // delivered after len edges (len = 2 or 4 from the first byte) and retires one edge later.
   logic        m_act = 1'b0;
   int          m_i = 0;
   int          m_len = 0;
   logic [31:0] m_base = 32'd0;
   logic [31:0] m_instr = 32'd0;

   always @(posedge clk_in or negedge rst_in) begin
      logic [7:0] b0;
      if (!rst_in) begin
         m_act = 1'b0; m_i = 0; m_len = 0; m_base = 32'd0; m_instr = 32'd0;
      end else if (rdy_in) begin
         if (need_flush_in) begin
            m_act = 1'b0;
         end else if (m_act) begin
            if (m_i == m_len) begin
               m_act = 1'b0;
            end else begin
               m_i++;
               if (m_i == m_len) begin
                  if (m_len == 2)
                     m_instr = {16'h0000, ram_byte(m_base + 32'd1), ram_byte(m_base)};
                  else
                     m_instr = {ram_byte(m_base + 32'd3), ram_byte(m_base + 32'd2),
                                ram_byte(m_base + 32'd1), ram_byte(m_base)};
               end
            end
         end else if (miss_in) begin
            m_act  = 1'b1;
            m_i    = 0;
            m_base = miss_addr_in;
            b0     = ram_byte(miss_addr_in);
            m_len  = (b0[1:0] == 2'b11) ? 4 : 2;
         end
      end
   end

   always @(negedge clk_in) begin
      check("m_busy",  {31'd0, mem_busy_out},  {31'd0, m_act});
      check("m_valid", {31'd0, mem_valid_out}, {31'd0, (m_act && m_i == m_len)});
      check("m_instr", mem_instr_out, m_instr);
      check("m_ram_wr", {31'd0, ram_wr}, 32'd0);
      if (!m_act)
         check("m_ram_a_idle", ram_a, 32'd0);
      else if (m_i < m_len)
         check("m_ram_a", ram_a, m_base + 32'(m_i));
   end

   // Call right after an edge; counts further edges until the valid cycle is seen.
   task automatic wait_valid(input int start_lat, output int lat);
      logic seen = 1'b0;
      lat = start_lat;
      for (int n = 0; n < 40 && !seen; n++) begin
         @(negedge clk_in);
         if (mem_valid_out) seen = 1'b1;
         else begin
            @(posedge clk_in);
            lat++;
         end
      end
      if (!seen) check("valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic issue_miss(input logic [31:0] addr);
      @(negedge clk_in); #1;
      miss_in = 1'b1; miss_addr_in = addr;
      @(posedge clk_in); #1;
      miss_in = 1'b0;
   endtask

   task automatic fetch(input string name, input logic [31:0] addr,
                        input logic [31:0] exp_instr, input int exp_lat);
      int lat;
      issue_miss(addr);
      wait_valid(0, lat);
      check({name, "_lat"}, 32'(lat), 32'(exp_lat));
      check({name, "_instr"}, mem_instr_out, exp_instr);
      @(negedge clk_in);
      check({name, "_busy_after"}, {31'd0, mem_busy_out}, 32'd0);
      check({name, "_valid_after"}, {31'd0, mem_valid_out}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int cnt;
      logic [31:0] wrap_seq [4];
      wrap_seq[0] = 32'hFFFF_FFFE; wrap_seq[1] = 32'hFFFF_FFFF;
      wrap_seq[2] = 32'h0000_0000; wrap_seq[3] = 32'h0000_0001;

      // reset state
      #2;
      check("rst_busy",  {31'd0, mem_busy_out},  32'd0);
      check("rst_valid", {31'd0, mem_valid_out}, 32'd0);
      check("rst_instr", mem_instr_out, 32'd0);
      check("rst_ram_a", ram_a, 32'd0);
      repeat (2) @(negedge clk_in);
      #1 rst_in = 1'b1;

      // 16-bit and 32-bit fetches
      fetch("f16", 32'h0000_0100, 32'h0000_4501, 2);
      fetch("f32", 32'h0000_0200, 32'h0010_0093, 4);

      // flush at E2 of a 32-bit fetch, then a fresh fetch
      issue_miss(32'h0000_0200);
      @(posedge clk_in); #1 need_flush_in = 1'b1;
      @(posedge clk_in); #1 need_flush_in = 1'b0;
      @(negedge clk_in);
      check("flush_busy", {31'd0, mem_busy_out}, 32'd0);
      repeat (5) begin
         @(negedge clk_in);
         check("flush_no_valid", {31'd0, mem_valid_out}, 32'd0);
      end
      fetch("f300", 32'h0000_0300, 32'h00a0_0513, 4);

      // stall for 3 cycles after E1
      issue_miss(32'h0000_0200);
      @(posedge clk_in); #1 rdy_in = 1'b0;
      repeat (3) begin
         @(negedge clk_in);
         check("stall_ram_a", ram_a, 32'h0000_0201);
         check("stall_busy", {31'd0, mem_busy_out}, 32'd1);
         @(posedge clk_in);
      end
      #1 rdy_in = 1'b1;
      wait_valid(4, lat);
      check("stall_lat", 32'(lat), 32'd7);
      check("stall_instr", mem_instr_out, 32'h0010_0093);

      // address wrap
      issue_miss(32'hFFFF_FFFE);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_in);
         check("wrap_ram_a", ram_a, wrap_seq[i]);
         @(posedge clk_in);
      end
      wait_valid(4, lat);
      check("wrap_lat", 32'(lat), 32'd4);
      check("wrap_instr", mem_instr_out, 32'h5634_1237);
      repeat (2) @(negedge clk_in);

      // flush and miss on the same edge: flush wins
      @(negedge clk_in); #1;
      miss_in = 1'b1; need_flush_in = 1'b1; miss_addr_in = 32'h0000_0100;
      @(posedge clk_in); #1;
      miss_in = 1'b0; need_flush_in = 1'b0;
      @(negedge clk_in);
      check("collide_busy", {31'd0, mem_busy_out}, 32'd0);

      // flush while stalled waits for rdy_in
      issue_miss(32'h0000_0200);
      @(posedge clk_in); #1;
      rdy_in = 1'b0; need_flush_in = 1'b1;
      repeat (2) begin
         @(negedge clk_in);
         check("stallflush_busy", {31'd0, mem_busy_out}, 32'd1);
         @(posedge clk_in);
      end
      #1 rdy_in = 1'b1;
      @(posedge clk_in); #1 need_flush_in = 1'b0;
      @(negedge clk_in);
      check("stallflush_done", {31'd0, mem_busy_out}, 32'd0);

      // asynchronous reset mid-RD
      issue_miss(32'h0000_0200);
      @(posedge clk_in); #3 rst_in = 1'b0;
      #1;
      check("arst_busy",  {31'd0, mem_busy_out},  32'd0);
      check("arst_valid", {31'd0, mem_valid_out}, 32'd0);
      check("arst_instr", mem_instr_out, 32'd0);
      check("arst_ram_a", ram_a, 32'd0);
      repeat (2) @(negedge clk_in);
      #1 rst_in = 1'b1;
      repeat (4) begin
         @(negedge clk_in);
         check("arst_no_valid", {31'd0, mem_valid_out}, 32'd0);
      end
      fetch("f400", 32'h0000_0400, 32'h0000_8082, 2);

      // back-to-back: miss held high, second accepted only after DONE
      @(negedge clk_in); #1;
      miss_in = 1'b1; miss_addr_in = 32'h0000_0100;
      @(posedge clk_in); #1;
      wait_valid(0, lat);
      check("b2b_first_lat", 32'(lat), 32'd2);
      cnt = 0;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk_in);
         cnt++;
         @(negedge clk_in);
         if (mem_valid_out) break;
      end
      check("b2b_gap", 32'(cnt), 32'd4);
      check("b2b_instr", mem_instr_out, 32'h0000_4501);
      #1 miss_in = 1'b0;
      repeat (3) @(negedge clk_in);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
